// File: rtl/program_loader.sv
// program_loader: boot/reload sequencer for program_memory.
// Receives a little-endian word count followed by little-endian 32-bit words
// over a byte valid/ready handshake, clears memory, writes the words at
// consecutive addresses and releases the CPU reset once the image is complete.
module program_loader #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        clear_mem,
  output logic        write_enable,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        load_done,
  output logic        error
);

  localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;          // lower three bytes of the word in progress
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] words_acc_q, words_acc_d;
  logic [31:0] timeout_q, timeout_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        byte_ready_q, byte_ready_d;
  logic        clear_mem_q, clear_mem_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;
  logic        error_q, error_d;
  logic        cpu_reset_q, cpu_reset_d;

  logic        fire_s;
  logic [31:0] full_word_s;
  logic [31:0] timeout_inc_s;

  assign fire_s        = byte_valid && byte_ready_q;
  assign full_word_s   = {byte_data, asm_q};
  assign timeout_inc_s = timeout_q + 32'd1;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    words_acc_d  = words_acc_q;
    timeout_d    = timeout_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    // the address steps past a word on the cycle after it is written
    wr_addr_d    = wr_en_q ? (wr_addr_q + 32'd4) : wr_addr_q;
    byte_ready_d = 1'b0;

    // collect the lower three bytes of a word; the fourth arrives with the write
    if (fire_s) begin
      case (byte_idx_q)
        2'd0:    asm_d[7:0]   = byte_data;
        2'd1:    asm_d[15:8]  = byte_data;
        2'd2:    asm_d[23:16] = byte_data;
        default: asm_d        = asm_q;
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
      timeout_d  = 32'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_IDLE;
      end
      S_CLEAR: begin
        state_d      = S_LEN;
        wr_addr_d    = BASE_ADDR;
        byte_idx_d   = 2'd0;
        asm_d        = 24'd0;
        timeout_d    = 32'd0;
        words_acc_d  = 32'd0;
        word_count_d = 32'd0;
        byte_ready_d = 1'b1;
      end
      S_LEN: begin
        if (fire_s) begin
          if (byte_idx_q == 2'd3) begin
            word_count_d = full_word_s;
            if (full_word_s == 32'd0) begin
              state_d = S_DONE;
            end else if (full_word_s > MEM_LIM) begin
              state_d = S_ERROR;
            end else begin
              state_d      = S_DATA;
              byte_ready_d = 1'b1;
            end
          end else begin
            byte_ready_d = 1'b1;
          end
        end else begin
          timeout_d = timeout_inc_s;
          if (timeout_inc_s >= TO_LIM) state_d = S_ERROR;
          else                         byte_ready_d = 1'b1;
        end
      end
      S_DATA: begin
        if (fire_s) begin
          if (byte_idx_q == 2'd3) begin
            wr_en_d     = 1'b1;
            wr_data_d   = full_word_s;
            words_acc_d = words_acc_q + 32'd1;
            // stop accepting once the final word is captured
            byte_ready_d = ((words_acc_q + 32'd1) != word_count_q);
          end else begin
            byte_ready_d = 1'b1;
          end
        end else if (!byte_ready_q) begin
          // final word is being written this cycle
          state_d = S_DONE;
        end else begin
          timeout_d = timeout_inc_s;
          if (timeout_inc_s >= TO_LIM) state_d = S_ERROR;
          else                         byte_ready_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_DONE;
      end
      S_ERROR: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    clear_mem_d = (state_d == S_CLEAR);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_LEN) || (state_d == S_DATA);
    load_done_d = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_reset_d = (state_d != S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'd0;
      word_count_q <= 32'd0;
      words_acc_q  <= 32'd0;
      timeout_q    <= 32'd0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 32'd0;
      wr_addr_q    <= BASE_ADDR;
      byte_ready_q <= 1'b0;
      clear_mem_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      error_q      <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      words_acc_q  <= words_acc_d;
      timeout_q    <= timeout_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      byte_ready_q <= byte_ready_d;
      clear_mem_q  <= clear_mem_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      error_q      <= error_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign clear_mem     = clear_mem_q;
  assign write_enable  = wr_en_q;
  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign load_done     = load_done_q;
  assign error         = error_q;

endmodule
